// File: rtl/cond_pkg.sv
// cond_pkg: shared types for the E-stage condition unit.
// Provides the ARM condition enum and NZCV bit positions.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition evaluator.
// Ports: cond (4b code), flags ({N,Z,C,V}) -> pass.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c & !z;
      LS: pass = !c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = !z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: E-stage NZCV register, condition gating and E/M controls.
// In: clk, reset_n, FlushE, IsArmE, CondE, FlagWriteE, Flags, ZeroE,
//     RegWriteE, MemWriteE, PCSrcE, BranchE.
// Out: CondExE, BranchTakenE (comb); RegWriteM, MemWriteM, PCSrcM,
//      FlagsQ (registered).
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       FlushE,
  input  logic       IsArmE,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  input  logic [3:0] Flags,
  input  logic       ZeroE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       PCSrcE,
  input  logic       BranchE,
  output logic       CondExE,
  output logic       BranchTakenE,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       PCSrcM,
  output logic [3:0] FlagsQ
);

  logic cond_pass;
  logic flag_en;
  logic rv_taken;

  cond_check u_check (
    .cond  (CondE),
    .flags (FlagsQ),
    .pass  (cond_pass)
  );

  assign CondExE = FlushE ? 1'b0
                 : (IsArmE ? cond_pass : 1'b1);

  assign rv_taken = PCSrcE | (BranchE & ZeroE);

  assign BranchTakenE = !FlushE &
    (IsArmE ? (PCSrcE & CondExE) : rv_taken);

  assign flag_en = IsArmE & CondExE & !FlushE;

  // Per-half enables select between old and new values, so an
  // unknown Flags input cannot leak into a half that is not written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      FlagsQ <= RESET_FLAGS;
    end else if (flag_en) begin
      if (FlagWriteE[1]) begin
        FlagsQ[FLAG_N] <= Flags[FLAG_N];
        FlagsQ[FLAG_Z] <= Flags[FLAG_Z];
      end
      if (FlagWriteE[0]) begin
        FlagsQ[FLAG_C] <= Flags[FLAG_C];
        FlagsQ[FLAG_V] <= Flags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
    end else begin
      RegWriteM <= RegWriteE & CondExE;
      MemWriteM <= MemWriteE & CondExE;
      PCSrcM    <= BranchTakenE;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed bench for cond_unit with a reference model.
// Model tracks NZCV and E/M controls; literals pin key cases.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       FlushE = 1'b0;
  logic       IsArmE = 1'b0;
  logic [3:0] CondE = 4'd0;
  logic [1:0] FlagWriteE = 2'd0;
  logic [3:0] Flags = 4'd0;
  logic       ZeroE = 1'b0;
  logic       RegWriteE = 1'b0;
  logic       MemWriteE = 1'b0;
  logic       PCSrcE = 1'b0;
  logic       BranchE = 1'b0;
  logic       CondExE, BranchTakenE;
  logic       RegWriteM, MemWriteM, PCSrcM;
  logic [3:0] FlagsQ;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  cond_unit #(.RESET_FLAGS(4'b0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .FlushE       (FlushE),
    .IsArmE       (IsArmE),
    .CondE        (CondE),
    .FlagWriteE   (FlagWriteE),
    .Flags        (Flags),
    .ZeroE        (ZeroE),
    .RegWriteE    (RegWriteE),
    .MemWriteE    (MemWriteE),
    .PCSrcE       (PCSrcE),
    .BranchE      (BranchE),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .PCSrcM       (PCSrcM),
    .FlagsQ       (FlagsQ)
  );

  always #5 clk = ~clk;

  // Reference model: codes pair up as (test, inverted test) by bit 0.
  function automatic bit m_cond(input logic [3:0] code,
                                input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return !code[0];
    endcase
    return base ^ code[0];
  endfunction

  logic [3:0] m_flags;
  bit m_rw, m_mw, m_pc;

  function automatic bit m_ce();
    if (FlushE) return 1'b0;
    if (!IsArmE) return 1'b1;
    return m_cond(CondE, m_flags);
  endfunction

  function automatic bit m_taken();
    if (FlushE) return 1'b0;
    if (IsArmE) return PCSrcE && m_ce();
    return PCSrcE || (BranchE && ZeroE);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_flags = 4'b0000;
      m_rw = 0; m_mw = 0; m_pc = 0;
    end else begin
      bit ce, tk;
      ce = m_ce();
      tk = m_taken();
      if (IsArmE && ce) begin
        if (FlagWriteE[1]) m_flags[3:2] = Flags[3:2];
        if (FlagWriteE[0]) m_flags[1:0] = Flags[1:0];
      end
      m_rw = RegWriteE && ce;
      m_mw = MemWriteE && ce;
      m_pc = tk;
    end
  end

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && reset_n) begin
      chk("m_condex", {3'b0, CondExE}, {3'b0, m_ce()});
      chk("m_taken", {3'b0, BranchTakenE}, {3'b0, m_taken()});
      chk("m_flags", FlagsQ, m_flags);
      chk("m_rwm", {3'b0, RegWriteM}, {3'b0, m_rw});
      chk("m_mwm", {3'b0, MemWriteM}, {3'b0, m_mw});
      chk("m_pcm", {3'b0, PCSrcM}, {3'b0, m_pc});
    end
  end

  task automatic drive(input bit arm, input logic [3:0] cond,
                       input logic [1:0] fw, input logic [3:0] fl,
                       input bit flush, input bit rw, input bit mw,
                       input bit pcs, input bit br, input bit z);
    IsArmE = arm; CondE = cond; FlagWriteE = fw; Flags = fl;
    FlushE = flush; RegWriteE = rw; MemWriteE = mw;
    PCSrcE = pcs; BranchE = br; ZeroE = z;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(1, 4'b1110, 2'b11, f, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got timeout want finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2;
    chk("rst_flags", FlagsQ, 4'b0000);
    chk("rst_m", {1'b0, RegWriteM, MemWriteM, PCSrcM}, 4'b0000);
    @(posedge clk); #1;
    idle();
    reset_n = 1'b1;
    tick();
    chk_on = 1'b1;

    // setter then conditional EQ
    drive(1, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 0, 0, 0);
    chk("al_ce", {3'b0, CondExE}, 4'b0001);
    tick();
    chk("set_0100", FlagsQ, 4'b0100);
    drive(1, 4'b0000, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0);
    chk("eq_ce", {3'b0, CondExE}, 4'b0001);
    tick();
    chk("eq_rwm", {3'b0, RegWriteM}, 4'b0001);
    set_flags(4'b0100);
    drive(1, 4'b0001, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0);
    chk("ne_ce", {3'b0, CondExE}, 4'b0000);
    tick();
    chk("ne_rwm", {3'b0, RegWriteM}, 4'b0000);

    // partial writes
    set_flags(4'b1111);
    chk("set_1111", FlagsQ, 4'b1111);
    drive(1, 4'b1110, 2'b10, 4'b0000, 0, 0, 0, 0, 0, 0);
    tick();
    chk("nz_only", FlagsQ, 4'b0011);
    drive(1, 4'b1110, 2'b01, 4'b0000, 0, 0, 0, 0, 0, 0);
    tick();
    chk("cv_only", FlagsQ, 4'b0000);

    // suppression
    drive(1, 4'b0000, 2'b11, 4'b1010, 0, 0, 1, 0, 0, 0);
    chk("fail_ce", {3'b0, CondExE}, 4'b0000);
    tick();
    chk("fail_flags", FlagsQ, 4'b0000);
    chk("fail_mwm", {3'b0, MemWriteM}, 4'b0000);
    drive(1, 4'b1110, 2'b11, 4'b1010, 1, 1, 1, 1, 0, 0);
    chk("flush_bt", {3'b0, BranchTakenE}, 4'b0000);
    tick();
    chk("flush_flags", FlagsQ, 4'b0000);
    chk("flush_m", {1'b0, RegWriteM, MemWriteM, PCSrcM}, 4'b0000);
    drive(0, 4'b1110, 2'b11, 4'b1010, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rv_flags", FlagsQ, 4'b0000);

    // signed compares
    set_flags(4'b1001);
    drive(1, 4'b1010, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("ge_1001", {3'b0, CondExE}, 4'b0001);
    drive(1, 4'b1011, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("lt_1001", {3'b0, CondExE}, 4'b0000);
    drive(1, 4'b1100, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("gt_1001", {3'b0, CondExE}, 4'b0001);
    tick();
    set_flags(4'b0100);
    drive(1, 4'b1100, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("gt_0100", {3'b0, CondExE}, 4'b0000);
    drive(1, 4'b1101, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("le_0100", {3'b0, CondExE}, 4'b0001);
    drive(1, 4'b1000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("hi_0100", {3'b0, CondExE}, 4'b0000);
    drive(1, 4'b1001, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
    chk("ls_0100", {3'b0, CondExE}, 4'b0001);
    tick();

    // unknown flags with no write request must not disturb NZCV
    drive(1, 4'b1110, 2'b00, 4'bxxxx, 0, 0, 0, 0, 0, 0);
    tick();
    chk("x_hold", FlagsQ, 4'b0100);

    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      drive(1, 4'b1111, 2'b00, 4'b0000, 0, 1, 0, 1, 0, 0);
      chk("nv_ce", {3'b0, CondExE}, 4'b0000);
      tick();
    end

    // RISC-V branch resolution
    drive(0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 1);
    chk("beq_bt", {3'b0, BranchTakenE}, 4'b0001);
    tick();
    chk("beq_pcm", {3'b0, PCSrcM}, 4'b0001);
    drive(0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 1, 0);
    chk("bne_bt", {3'b0, BranchTakenE}, 4'b0000);
    tick();
    chk("bne_pcm", {3'b0, PCSrcM}, 4'b0000);
    drive(0, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 1, 0, 0);
    chk("jal_bt", {3'b0, BranchTakenE}, 4'b0001);
    tick();
    chk("jal_pcm", {3'b0, PCSrcM}, 4'b0001);

    // reset in the middle of a flag-setting instruction
    drive(1, 4'b1110, 2'b11, 4'b1111, 0, 1, 1, 1, 0, 0);
    tick();
    chk("pre_flags", FlagsQ, 4'b1111);
    chk("pre_m", {1'b0, RegWriteM, MemWriteM, PCSrcM}, 4'b0111);
    drive(1, 4'b1110, 2'b11, 4'b1010, 0, 1, 1, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_flags", FlagsQ, 4'b0000);
    chk("mid_rst_m", {1'b0, RegWriteM, MemWriteM, PCSrcM}, 4'b0000);
    tick();
    chk("rst_hold", FlagsQ, 4'b0000);
    idle();
    reset_n = 1'b1;
    tick();
    chk("post_rst", FlagsQ, 4'b0000);
    chk("post_rst_m", {1'b0, RegWriteM, MemWriteM, PCSrcM}, 4'b0000);
    idle();
    tick();

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
